// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator: FSM state encoding
// and the field layout of the flat cfg word (fields are W bits wide each).
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PER_FIELD = 0;
  localparam int NUM_FIELD = 1;

  function automatic int rise_field(input int ch);
    return 2 * ch + 2;
  endfunction

  function automatic int fall_field(input int ch);
    return 2 * ch + 3;
  endfunction

  function automatic int field_lsb(input int field, input int w);
    return field * w;
  endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse output: registered level set on cntr==rise, cleared on cntr==fall
// (fall wins on a tie), forced low while clear is asserted.
module pulse_gen_channel #(
  parameter int W = 32
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] cntr,
  input  logic [W-1:0] rise,
  input  logic [W-1:0] fall,
  input  logic         clear,
  output logic         dout
);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dout <= 1'b0;
    end else if (clear) begin
      dout <= 1'b0;
    end else if (cntr == fall) begin
      dout <= 1'b0;
    end else if (cntr == rise) begin
      dout <= 1'b1;
    end
  end

endmodule

// File: rtl/pulse_generator_multi.sv
// Triggered multi-channel burst pulse generator sharing one period counter.
// Define PULSE_GEN_BURST_EN to honour the burst count N (otherwise runs end only on stop).
//
//   state | meaning
//   IDLE  | waiting for trg; counter held at 0, outputs low
//   RUN   | period counter running, channels comparing against latched cfg
//   DONE  | one-cycle completion strobe after the last burst period
module pulse_generator_multi
  import pulse_gen_pkg::*;
#(
  parameter int CNTR_WIDTH = 32,
  parameter int CHANNELS   = 4
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [CNTR_WIDTH*(2*CHANNELS+2)-1:0]  cfg,
  input  logic                                  trg,
  input  logic                                  stop,
  output logic [CHANNELS-1:0]                   dout,
  output logic                                  busy,
  output logic                                  done
);

  localparam int W = CNTR_WIDTH;

  state_t         state;
  logic [W-1:0]   cntr;
  logic [W-1:0]   per_lat;
  logic [W-1:0]   rise_lat [CHANNELS];
  logic [W-1:0]   fall_lat [CHANNELS];
  logic           period_end;
  logic           burst_end;
  logic           accept;
  logic           ch_clear;

  assign period_end = (cntr == per_lat);
  assign accept     = trg && !stop;
  // Channels update only on RUN cycles that are not being aborted.
  assign ch_clear   = (state != RUN) || stop;

`ifdef PULSE_GEN_BURST_EN
  logic [W-1:0] idx;
  logic [W-1:0] num_lat;
  logic         done_q;

  assign burst_end = period_end && (num_lat != '0) && (idx == num_lat - W'(1));
  assign done      = done_q;
`else
  logic unused_num;

  assign burst_end  = 1'b0;
  assign done       = 1'b0;
  assign unused_num = ^cfg[field_lsb(NUM_FIELD, W) +: W];
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      cntr    <= '0;
      per_lat <= '0;
      busy    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        rise_lat[i] <= '0;
        fall_lat[i] <= '0;
      end
`ifdef PULSE_GEN_BURST_EN
      idx     <= '0;
      num_lat <= '0;
      done_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= RUN;
            busy    <= 1'b1;
            cntr    <= '0;
            per_lat <= cfg[field_lsb(PER_FIELD, W) +: W];
            for (int i = 0; i < CHANNELS; i++) begin
              rise_lat[i] <= cfg[field_lsb(rise_field(i), W) +: W];
              fall_lat[i] <= cfg[field_lsb(fall_field(i), W) +: W];
            end
`ifdef PULSE_GEN_BURST_EN
            idx     <= '0;
            num_lat <= cfg[field_lsb(NUM_FIELD, W) +: W];
`endif
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            cntr  <= '0;
          end else if (burst_end) begin
            state <= DONE;
            busy  <= 1'b0;
            cntr  <= '0;
`ifdef PULSE_GEN_BURST_EN
            done_q <= 1'b1;
`endif
          end else if (period_end) begin
            cntr <= '0;
`ifdef PULSE_GEN_BURST_EN
            // Saturate so an unbounded run never wraps the index.
            if (idx != '1) idx <= idx + W'(1);
`endif
          end else begin
            cntr <= cntr + W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef PULSE_GEN_BURST_EN
          done_q <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cntr  <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pulse_gen_channel #(.W(W)) u_ch (
      .aclk    (aclk),
      .aresetn (aresetn),
      .cntr    (cntr),
      .rise    (rise_lat[g]),
      .fall    (fall_lat[g]),
      .clear   (ch_clear),
      .dout    (dout[g])
    );
  end

endmodule

// File: tb/tb_pulse_generator_multi.sv
// Table-driven bench for pulse_generator_multi (W=32, 4 channels); expectations
// come from the edge-timing rules, with hand sequences for async reset.
module tb_pulse_generator_multi;

  localparam int W  = 32;
  localparam int CH = 4;
  localparam int CW = W * (2 * CH + 2);
`ifdef PULSE_GEN_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [CW-1:0] cfg;
  logic          trg;
  logic          stop;
  logic [CH-1:0] dout;
  logic          busy;
  logic          done;

  pulse_generator_multi #(.CNTR_WIDTH(W), .CHANNELS(CH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .cfg     (cfg),
    .trg     (trg),
    .stop    (stop),
    .dout    (dout),
    .busy    (busy),
    .done    (done)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int            tag;
    int            off;
    logic [CW-1:0] cfg;
    logic          trg;
    logic          stop;
    logic [CH-1:0] exp_dout;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vecs[$];
  int   rr[CH];
  int   ff[CH];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int tag, input int off,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [scenario %0d, cycle %0d]: got %0h, expected %0h", nm, tag, off, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [CW-1:0] make_cfg(input int p, input int n);
    logic [CW-1:0] c;
    c = '0;
    c[0 +: W] = p;
    c[W +: W] = n;
    for (int i = 0; i < CH; i++) begin
      c[(2*i+2)*W +: W] = rr[i];
      c[(2*i+3)*W +: W] = ff[i];
    end
    return c;
  endfunction

  // Level of a channel after edge k+j of a run triggered at edge k.
  function automatic bit chan_level(input int j, input int p, input int r, input int f);
    int c, q;
    if (j < 1) return 1'b0;
    if (r > p || r == f) return 1'b0;
    if (f > p) return (j - 1) >= r;
    c = (j - 1) % (p + 1);
    q = (j - 1) / (p + 1);
    if (r < f) return (c >= r) && (c < f);
    return (c >= r) || ((c < f) && (q >= 1));
  endfunction

  task automatic add_idle(input bit t, input bit s, input int tag);
    vec_t v;
    v.tag = tag; v.off = 0; v.cfg = make_cfg(9, 1);
    v.trg = t; v.stop = s;
    v.exp_dout = '0; v.exp_busy = 1'b0; v.exp_done = 1'b0;
    vecs.push_back(v);
  endtask

  // Record 0 carries the trigger; p_mid/trg_mid change cfg and re-pulse trg mid-run.
  task automatic add_run(input int p, input int n, input int cycles, input int stop_at,
                         input int p_mid, input bit trg_mid, input int tag);
    vec_t          v;
    logic [CW-1:0] c0, c1;
    bit            bounded;
    int            e, end_j;
    c0      = make_cfg(p, n);
    c1      = make_cfg(p_mid, n);
    bounded = BURST && (n != 0);
    e       = n * (p + 1);
    end_j   = bounded ? e : stop_at;
    for (int j = 0; j < cycles; j++) begin
      v.tag  = tag;
      v.off  = j;
      v.cfg  = (j == 0) ? c0 : c1;
      v.trg  = (j == 0) || (trg_mid && j < end_j);
      v.stop = (j == stop_at);
      v.exp_dout = '0;
      v.exp_busy = 1'b0;
      v.exp_done = 1'b0;
      if (!((stop_at >= 0 && j >= stop_at) || (bounded && j > e))) begin
        for (int i = 0; i < CH; i++) v.exp_dout[i] = chan_level(j, p, rr[i], ff[i]);
        v.exp_busy = !(bounded && j == e);
        v.exp_done = bounded && (j == e);
      end
      vecs.push_back(v);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    trg     = 1'b0;
    stop    = 1'b0;
    cfg     = '0;

    #12;
    chk("rst_dout", 0, 0, dout, 0);
    chk("rst_busy", 0, 0, busy, 0);
    chk("rst_done", 0, 0, done, 0);
    #10 aresetn = 1'b1;
    step();
    chk("post_rst_busy", 0, 1, busy, 0);
    chk("post_rst_dout", 0, 1, dout, 0);

    // Scenario 0: trg and stop together in IDLE stays idle.
    rr = '{2, 15, 15, 15}; ff = '{5, 15, 15, 15};
    add_idle(1'b1, 1'b1, 0);
    add_idle(1'b0, 1'b0, 0);
    // 1: burst P=9 N=3; 2: abort at +14; 3: clean restart right after the abort.
    add_run(9, 3, 32, BURST ? -1 : 31, 9, 1'b0, 1);
    add_run(9, 3, 15, 14, 9, 1'b0, 2);
    add_run(9, 3, 32, BURST ? -1 : 31, 9, 1'b0, 3);
    // 4: channel independence.
    rr = '{0, 4, 7, 12}; ff = '{1, 8, 7, 3};
    add_run(9, 1, BURST ? 12 : 22, BURST ? -1 : 21, 9, 1'b0, 4);
    // 5: cfg change + trg during RUN ignored; 6: new P applies on next trigger.
    rr = '{2, 3, 6, 9}; ff = '{5, 1, 20, 0};
    add_run(9, 2, 22, BURST ? -1 : 21, 4, 1'b1, 5);
    add_run(4, 1, BURST ? 7 : 12, BURST ? -1 : 11, 4, 1'b0, 6);
    // 7: P=0 single-cycle periods.
    rr = '{0, 0, 3, 0}; ff = '{5, 0, 3, 1};
    add_run(0, 4, BURST ? 6 : 10, BURST ? -1 : 9, 0, 1'b0, 7);
    // 8: unbounded run, terminated only by stop.
    rr = '{2, 0, 15, 15}; ff = '{5, 9, 15, 15};
    add_run(9, BURST ? 0 : 3, 1101, 1100, 9, 1'b0, 8);

    for (int i = 0; i < vecs.size(); i++) begin
      cfg  = vecs[i].cfg;
      trg  = vecs[i].trg;
      stop = vecs[i].stop;
      step();
      chk("dout", vecs[i].tag, vecs[i].off, dout, vecs[i].exp_dout);
      chk("busy", vecs[i].tag, vecs[i].off, busy, vecs[i].exp_busy);
      chk("done", vecs[i].tag, vecs[i].off, done, vecs[i].exp_done);
    end
    trg  = 1'b0;
    stop = 1'b0;

    // Async reset in the middle of a pulse, asserted between clock edges.
    rr = '{2, 15, 15, 15}; ff = '{5, 15, 15, 15};
    cfg = make_cfg(9, 3);
    trg = 1'b1;
    step();
    trg = 1'b0;
    chk("ar_busy_start", 9, 0, busy, 1);
    step(); step(); step();
    chk("ar_dout_high", 9, 3, dout, 4'b0001);
    #3 aresetn = 1'b0;
    #1;
    chk("ar_dout_now", 9, 4, dout, 0);
    chk("ar_busy_now", 9, 4, busy, 0);
    chk("ar_done_now", 9, 4, done, 0);
    step();
    chk("ar_busy_held", 9, 5, busy, 0);
    #3 aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_idle_busy", 9, 6 + i, busy, 0);
      chk("ar_idle_dout", 9, 6 + i, dout, 0);
    end
    trg = 1'b1;
    step();
    trg = 1'b0;
    chk("ar_retrg_busy", 10, 0, busy, 1);
    step(); step(); step();
    chk("ar_retrg_dout", 10, 3, dout, 4'b0001);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("ar_stop_busy", 10, 4, busy, 0);
    chk("ar_stop_dout", 10, 4, dout, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_generator_multi.md
# pulse_generator_multi

Multi-channel, triggered burst pulse generator. It is the parametrised successor of the single-channel pulse generator. One free-running period counter drives CHANNELS independent rise/fall comparators. A trigger starts a run of N periods, or an unbounded run. It sits between the configuration register bus and GPIO/DAC gating logic, and produces aligned timing strobes such as TX gate, RX blank and ADC window.

## Interface
- CNTR_WIDTH, 32: counter and time-field width W.
- CHANNELS, 4: number of pulse outputs, 1..16.
- aclk  in  1  clock; all logic is in this domain.
- aresetn  in  1  asynchronous active-low reset.
- cfg  in  W*(2*CHANNELS+2)  bits [W-1:0] period P (period = P+1 cycles); [2W-1:W] burst count N; channel i rise R_i at [(2i+3)W-1:(2i+2)W], fall F_i at [(2i+4)W-1:(2i+3)W].
- trg  in  1  start request, sampled at every aclk edge.
- stop  in  1  abort request, sampled at every aclk edge.
- dout  out  CHANNELS  pulse outputs.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at normal burst completion.

## Operation
- States:
  - IDLE: counter 0, dout 0.
  - RUN: counting.
  - DONE: one cycle.
  - DONE always returns to IDLE.
- IDLE with trg=1: the edge moves to RUN, clears the counter and period index, and latches all of cfg. cfg changes during RUN have no effect.
- RUN, each cycle:
  - If cntr==P_lat: cntr<=0 and period index += 1.
  - Otherwise cntr<=cntr+1.
  - Counter arithmetic is unsigned, W bits. P=0 gives a 1-cycle period.
- Channel i, registered:
  - next = 1 when cntr==R_i.
  - next = 0 when cntr==F_i.
  - Otherwise hold.
  - Fall wins when R_i==F_i, so the channel stays 0.
  - R_i>P never rises. F_i>P with R_i≤P gives a pulse that persists across periods.
- Burst end (burst enabled, N≠0): in RUN, when cntr==P_lat and period index==N-1, the edge moves to DONE.
- stop=1 in RUN: the next edge moves to IDLE and dout<=0. No done pulse is produced. stop has priority over burst end.
- trg in RUN or DONE is ignored. trg and stop both high in IDLE: stop wins and the block stays in IDLE.
- Edge leaving DONE: dout<=0.
- Reset, including mid-run: immediately state=IDLE, counter, index and latched cfg=0, dout=0, busy=0, done=0.

## Timing
- Trigger accepted at edge k: busy=1 from edge k.
- dout_i rises at edge k+R_i+1 and falls at edge k+F_i+1. The 1-cycle latency comes from the output register.
- Each later period shifts these edges by P+1.
- Burst of N periods:
  - DONE is entered at edge k+N(P+1).
  - busy falls at that edge.
  - done is high from edge k+N(P+1) to edge k+N(P+1)+1.
  - IDLE and dout=0 from edge k+N(P+1)+1.
- A retrigger is accepted at the earliest 2 cycles after burst end.
- Period-index width: W bits. N saturates the index; no wrap occurs before the compare.

## Configuration
- PULSE_GEN_BURST_EN defined: N is honoured. N=0 means unbounded, ended only by stop; done never asserts in that case.
- PULSE_GEN_BURST_EN undefined:
  - The period index and the DONE state are removed.
  - The N field is ignored but stays in the cfg layout.
  - Runs end only via stop.
  - done is tied 0.

## Structure
- Shared package pulse_gen_pkg:
  - state encoding IDLE/RUN/DONE
  - cfg field offset constants/functions for P, N, R_i, F_i
- Sub-module pulse_gen_channel, instantiated CHANNELS times:
  - inputs: cntr, R, F, clear
  - output: registered dout bit, using fall-priority compare

## Test plan
- Single-channel burst: W=32, P=9, N=3, R0=2, F0=5, trg pulse at edge k. Required:
  - dout[0] high in cycles [k+3,k+6), [k+13,k+16), [k+23,k+26)
  - busy low at k+30
  - done high for exactly one cycle from k+30
- Channel independence: R=0/F=1, R=4/F=8, R=7/F=7, R=12/F=3 with P=9, N=1. Required:
  - ch0 1-cycle pulse
  - ch1 4-cycle pulse
  - ch2 never high
  - ch3 never high
- Abort: stop at edge k+14 of the scenario 1 run. Required:
  - IDLE and dout=0 from k+14
  - done never asserts
  - trg at k+15 restarts cleanly
- Retrigger/cfg change: change P to 4 and pulse trg during RUN. Required: no effect until the burst ends; the new P applies only on the next trigger.
- Asynchronous reset: aresetn low mid-pulse, between clock edges. Required:
  - dout, busy and done are 0 immediately
  - after release, the block is idle until trg
- Unbounded run: N=0, or macro undefined with any N. Required:
  - periodic output for ≥1000 cycles
  - done stays 0
  - only stop terminates the run
